shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits, legal range 2..32.
REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Start, input, 1, request to begin a multiply.
REQ-005 SHALL have port Signed, input, 1, mode select: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port A, input, WIDTH, multiplicand.
REQ-007 SHALL have port B, input, WIDTH, multiplier.
REQ-008 SHALL have port Product, output, 2*WIDTH, result register.
REQ-009 SHALL have port Busy, output, 1, high while iterations are in progress.
REQ-010 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port AddRshift, output, 1, step indicator: current step adds (or subtracts) the multiplicand, then shifts.
REQ-012 SHALL have port Rshift, output, 1, step indicator: current step shifts only.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; an iteration counter of ceil(log2(WIDTH+1)) bits.
REQ-014 SHALL, in IDLE or DONE with Start=1 at an edge, latch A, B, Signed, clear the accumulator and counter, and enter BUSY.
REQ-015 SHALL ignore Start while in BUSY; latched operands and mode SHALL NOT change mid-operation.
REQ-016 SHALL remain in BUSY for exactly WIDTH cycles, performing one iteration per edge, with Busy=1 throughout.
REQ-017 SHALL, per iteration: multiplier LSB=1 -> add multiplicand to upper accumulator, then right shift; LSB=0 -> right shift only.
REQ-018 SHALL, in signed mode, sign-extend the multiplicand, use an arithmetic right shift, and subtract instead of add on the final (MSB) iteration.
REQ-019 SHALL, in unsigned mode, keep the adder carry-out as the shifted-in bit (no overflow loss).
REQ-020 SHALL drive AddRshift=1 in a BUSY cycle whose current multiplier LSB=1, Rshift=1 when it is 0; exactly one high in BUSY, both 0 in IDLE and DONE.
REQ-021 SHALL transition BUSY->DONE on the edge completing iteration WIDTH; in DONE, Done=1, Busy=0, Product = exact 2*WIDTH-bit product per latched mode.
REQ-022 SHALL leave DONE after one cycle: to BUSY if Start=1 (back-to-back), else to IDLE; Done SHALL be high for exactly one cycle per operation.
REQ-023 SHALL hold Product stable from DONE until the next completion; Product SHALL NOT show partial results while BUSY.
REQ-024 SHALL produce a latency of WIDTH+1 edges from the edge sampling Start to the first cycle with Done=1.
REQ-025 SHALL treat operands of 0 correctly (Product=0, no AddRshift pulses when B=0).

Reset
REQ-026 SHALL, with Reset=1 at an edge, enter IDLE and clear Product, Busy, Done, AddRshift, Rshift, counter and accumulator to 0.
REQ-027 SHALL give Reset priority over Start when both are high on the same edge.
REQ-028 SHALL abort any in-flight operation on Reset mid-BUSY, with no Done pulse for that operation.

Verification (WIDTH=8)
REQ-029 SHALL cover: unsigned A=255, B=255 -> Busy high 8 cycles, Done pulse on 9th edge, Product=0xFE01.
REQ-030 SHALL cover: signed A=0x80 (-128), B=0x80 (-128) -> Product=0x4000; signed A=0xFD (-3), B=5 -> Product=0xFFF1.
REQ-031 SHALL cover: unsigned A=200, B=0 -> Product=0, AddRshift never high, Rshift high all 8 BUSY cycles.
REQ-032 SHALL cover: Start pulsed again during BUSY with new operands -> ignored; Product reflects original operands.
REQ-033 SHALL cover: Start held high in DONE cycle -> Busy reasserts next cycle, second Done exactly 9 edges later, both products correct.
REQ-034 SHALL cover: Reset asserted after 4 BUSY cycles -> next cycle Busy=0, Done=0, Product=0, FSM in IDLE, no Done pulse.

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, unsigned or two's-complement.
// Product is only written on completion, so it never shows partial results.
module shift_add_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 Signed,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 Busy,
   output logic                 Done,
   output logic                 AddRshift,
   output logic                 Rshift
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state;
   logic [WIDTH-1:0]     mcand;
   logic                 mode;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        count;

   logic [WIDTH:0]       hi_ext;
   logic [WIDTH:0]       m_ext;
   logic [WIDTH:0]       sum;
   logic                 last;
   logic [2*WIDTH-1:0]   acc_next;

   // acc holds {partial product, remaining multiplier}; the extra sum bit is the
   // carry (unsigned) or the true sign (signed) and becomes the shifted-in MSB.
   always_comb begin
      hi_ext = {mode & acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
      m_ext  = {mode & mcand[WIDTH-1], mcand};
      last   = (count == CW'(WIDTH - 1));
      if (acc[0]) begin
         // MSB of a two's-complement multiplier carries negative weight
         sum = (mode && last) ? (hi_ext - m_ext) : (hi_ext + m_ext);
      end else begin
         sum = hi_ext;
      end
      acc_next = {sum, acc[WIDTH-1:1]};
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state     <= IDLE;
         mcand     <= '0;
         mode      <= 1'b0;
         acc       <= '0;
         count     <= '0;
         Product   <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         AddRshift <= 1'b0;
         Rshift    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               Done <= 1'b0;
               if (Start) begin
                  mcand     <= A;
                  mode      <= Signed;
                  acc       <= {{WIDTH{1'b0}}, B};
                  count     <= '0;
                  Busy      <= 1'b1;
                  AddRshift <= B[0];
                  Rshift    <= ~B[0];
                  state     <= BUSY;
               end else begin
                  Busy      <= 1'b0;
                  AddRshift <= 1'b0;
                  Rshift    <= 1'b0;
                  state     <= IDLE;
               end
            end
            BUSY: begin
               acc   <= acc_next;
               count <= count + 1'b1;
               if (last) begin
                  Product   <= acc_next;
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
                  AddRshift <= 1'b0;
                  Rshift    <= 1'b0;
                  state     <= DONE;
               end else begin
                  // step indicators describe the iteration about to happen
                  AddRshift <= acc_next[0];
                  Rshift    <= ~acc_next[0];
               end
            end
            default: begin
               Busy      <= 1'b0;
               Done      <= 1'b0;
               AddRshift <= 1'b0;
               Rshift    <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult (WIDTH=8): per-cycle compare against a transaction-level model
// plus directed operations with hand-computed products.
module tb_shift_add_mult;

   localparam int W = 8;

   logic            CLK = 1'b0;
   logic            Reset;
   logic            Start;
   logic            Signed;
   logic [W-1:0]    A;
   logic [W-1:0]    B;
   logic [2*W-1:0]  Product;
   logic            Busy;
   logic            Done;
   logic            AddRshift;
   logic            Rshift;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 CLK = ~CLK;

   shift_add_mult #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Start     (Start),
      .Signed    (Signed),
      .A         (A),
      .B         (B),
      .Product   (Product),
      .Busy      (Busy),
      .Done      (Done),
      .AddRshift (AddRshift),
      .Rshift    (Rshift)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
      longint pa;
      longint pb;
      pa = s ? longint'($signed(a)) : longint'(a);
      pb = s ? longint'($signed(b)) : longint'(b);
      return (2*W)'(pa * pb);
   endfunction

   // Model: mk = 0 idle, 1..W = k-th busy cycle, W+1 = done cycle
   int             mk = 0;
   logic [W-1:0]   mb = '0;
   logic [2*W-1:0] mres = '0;
   logic [2*W-1:0] mprod = '0;

   always @(posedge CLK) begin
      if (Reset) begin
         mk    <= 0;
         mprod <= '0;
      end else if ((mk == 0 || mk == W + 1) && Start) begin
         mk   <= 1;
         mb   <= B;
         mres <= ref_mul(A, B, Signed);
      end else if (mk >= 1 && mk < W) begin
         mk <= mk + 1;
      end else if (mk == W) begin
         mk    <= W + 1;
         mprod <= mres;
      end else begin
         mk <= 0;
      end
   end

   logic busy_e;
   logic lsb_e;

   always @(negedge CLK) begin
      if (chk_en) begin
         busy_e = (mk >= 1 && mk <= W);
         lsb_e  = 1'b0;
         if (busy_e) lsb_e = mb[mk-1];
         check("cyc_busy", Busy, busy_e);
         check("cyc_done", Done, mk == W + 1);
         check("cyc_addrshift", AddRshift, busy_e & lsb_e);
         check("cyc_rshift", Rshift, busy_e & ~lsb_e);
         check("cyc_product", Product, mprod);
      end
   end

   int busy_tot = 0;
   int addr_tot = 0;
   int rsh_tot  = 0;
   int done_tot = 0;

   always @(negedge CLK) begin
      if (chk_en) begin
         busy_tot += int'(Busy);
         addr_tot += int'(AddRshift);
         rsh_tot  += int'(Rshift);
         done_tot += int'(Done);
      end
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      A = a;
      B = b;
      Signed = s;
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
   endtask

   // Returns number of further negedges waited until Done is seen
   task automatic wait_done(input string name, output int n);
      n = 0;
      while (!Done && n < 3 * W) begin
         @(negedge CLK);
         n++;
      end
      if (!Done) check({name, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2*W-1:0] exp,
                         output int bc, output int ac, output int rc);
      int b0, a0, r0, n;
      b0 = busy_tot;
      a0 = addr_tot;
      r0 = rsh_tot;
      start_op(a, b, s);
      wait_done(name, n);
      check({name, "_latency"}, n + 1, W + 1);
      check({name, "_product"}, Product, exp);
      bc = busy_tot - b0;
      ac = addr_tot - a0;
      rc = rsh_tot - r0;
   endtask

   initial begin
      int bc, ac, rc, n, d0;
      Reset = 1'b1;
      Start = 1'b0;
      Signed = 1'b0;
      A = '0;
      B = '0;
      repeat (2) @(negedge CLK);
      chk_en = 1'b1;
      check("reset_busy", Busy, 0);
      check("reset_done", Done, 0);
      check("reset_product", Product, 0);
      Reset = 1'b0;
      @(negedge CLK);

      run_op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, bc, ac, rc);
      check("u255x255_busy_cycles", bc, 8);
      check("u255x255_addrshift_cycles", ac, 8);
      @(negedge CLK);

      run_op("s_m128x_m128", 8'h80, 8'h80, 1'b1, 16'h4000, bc, ac, rc);
      run_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, bc, ac, rc);
      run_op("s_127x_m128", 8'h7F, 8'h80, 1'b1, 16'hC080, bc, ac, rc);

      run_op("u200x0", 8'd200, 8'd0, 1'b0, 16'h0000, bc, ac, rc);
      check("u200x0_addrshift_cycles", ac, 0);
      check("u200x0_rshift_cycles", rc, 8);
      run_op("u0x255", 8'd0, 8'hFF, 1'b0, 16'h0000, bc, ac, rc);
      check("u0x255_addrshift_cycles", ac, 8);

      // Start during BUSY with new operands must be ignored
      start_op(8'd12, 8'd13, 1'b0);
      repeat (2) @(negedge CLK);
      A = 8'd99;
      B = 8'd77;
      Signed = 1'b1;
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      wait_done("ignore_start", n);
      check("ignore_start_product", Product, 16'h009C);
      @(negedge CLK);

      // Back-to-back: Start held high through the DONE cycle
      A = 8'd7;
      B = 8'd9;
      Signed = 1'b0;
      Start = 1'b1;
      @(negedge CLK);
      wait_done("b2b_first", n);
      check("b2b_first_latency", n + 1, W + 1);
      check("b2b_first_product", Product, 16'h003F);
      A = 8'hFF;
      B = 8'h02;
      Signed = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      check("b2b_busy_reassert", Busy, 1);
      wait_done("b2b_second", n);
      check("b2b_second_gap", n + 1, W + 1);
      check("b2b_second_product", Product, 16'hFFFE);
      @(negedge CLK);

      // Reset wins over Start on the same edge
      Reset = 1'b1;
      Start = 1'b1;
      A = 8'd3;
      B = 8'd3;
      @(negedge CLK);
      Reset = 1'b0;
      Start = 1'b0;
      check("rst_prio_busy", Busy, 0);
      check("rst_prio_product", Product, 0);
      @(negedge CLK);
      check("rst_prio_busy_after", Busy, 0);

      // Abort after 4 BUSY cycles
      start_op(8'd5, 8'd6, 1'b0);
      repeat (3) @(negedge CLK);
      check("abort_pre_busy", Busy, 1);
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      check("abort_busy", Busy, 0);
      check("abort_done", Done, 0);
      check("abort_product", Product, 0);
      d0 = done_tot;
      repeat (12) @(negedge CLK);
      check("abort_no_done", done_tot - d0, 0);

      run_op("u5x6_recover", 8'd5, 8'd6, 1'b0, 16'h001E, bc, ac, rc);
      repeat (2) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
